mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory between the pipelined core's instruction fetch (IF) and data-memory (MEM) stages, replacing separate instruction and data memories. Sits between the PC/fetch stage, the EX/MEM pipeline register outputs and an external memory with a ready handshake. Serializes accesses with a small FSM and produces per-stage stall requests for the hazard logic. Data accesses win by default; an optional guard bounds fetch starvation.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, consecutive data grants tolerated while a fetch waits; used only with the guard; range 1..15

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched instruction; valid while if_done=1
- if_done  out  1  one-cycle completion pulse, registered
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data; valid while dm_done=1
- dm_done  out  1  one-cycle completion pulse, registered
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_wdata  out  DATA_WIDTH  memory write data, registered
- mem_ready  in  1  memory accepts or completes the access in this cycle; mem_rdata valid with it
- mem_rdata  in  DATA_WIDTH  memory read data
- stall_if  out  1  combinational: if_req & ~if_done
- stall_mem  out  1  combinational: dm_req & ~dm_done

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE: if dm_req, grant data. Otherwise, if if_req, grant fetch. Otherwise, stay.
  - On grant: load mem_req=1 and mem_we/mem_addr/mem_wdata from the winner; mem_we=0 and mem_wdata=0 for fetch.
  - Go to BUSY_IF or BUSY_DM.
- BUSY_x: hold mem_* stable until mem_ready=1.
  - On mem_ready: clear mem_req and mem_we.
  - Capture mem_rdata into if_rdata (fetch) or dm_rdata (load). A store leaves dm_rdata unchanged.
  - Pulse the matching done for the next cycle and go to RESP.
- RESP: done=1 for exactly this cycle. No arbitration, because the requester's req is still high this cycle for the completed access. Next state is IDLE.
- if_rdata and dm_rdata hold their last value between accesses.
- All outputs are 0 after reset.
- Reset during BUSY_x: drop mem_req the next cycle and abandon the access. No done is issued.

## Timing
- Minimum latency, counted from req high in IDLE at cycle 0:
  - mem_req rises at cycle 1.
  - mem_ready at cycle 1 at the earliest.
  - done at cycle 2.
- Each additional wait cycle of mem_ready adds one cycle.
- Back-to-back: a new request is arbitrated in the IDLE cycle following RESP. Throughput is one access per 3 cycles at zero wait states.
- Simultaneous if_req and dm_req in IDLE: data wins, and fetch waits with stall_if=1.
- A request arriving during BUSY or RESP waits for IDLE. Its stall output is already 1.
- mem_ready while mem_req=0 is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant, and clears on an IDLE cycle with if_req=0.
  - When the counter equals STARVE_LIMIT and if_req=1, fetch wins the next IDLE arbitration even if dm_req=1.
  - Reset clears the counter.
- Not defined: strict data priority and no counter logic.

## Test plan
- Single fetch, if_addr=0x0000_0040, mem_ready tied 1, mem_rdata=0x2008_0005 -> mem_req high in cycle 1 with mem_addr=0x40 and mem_we=0; if_done=1 and if_rdata=0x2008_0005 in cycle 2; stall_if=0 in cycle 2.
- Store dm_addr=0x10, dm_wdata=0xDEAD_BEEF, mem_ready delayed 3 cycles -> mem_we=1 and signals stable for 4 cycles; dm_done 1 cycle after mem_ready; dm_rdata unchanged.
- if_req and dm_req rise together (load 0x20, fetch 0x44) -> data served first; the fetch is granted in the IDLE cycle after dm_done; stall_if high throughout.
- rst asserted during BUSY_DM -> next cycle mem_req=0, state IDLE, no dm_done, all outputs 0.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=2, dm_req and if_req held high continuously -> grant order is data, data, fetch, data, data, fetch.
- Without the macro, same stimulus -> fetch is never granted while dm_req is high.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Core/memory bundle for the shared unified-memory port.
// Fetch, data and memory-side signals; slave = arbiter, master = core/memory.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ready, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ready, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage accesses onto one single-port memory.
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave).
// Macro ARB_STARVE_GUARD_EN: bound fetch starvation to STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT out of range 1..15");
    end

    state_t                state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic                  if_done_q;
    logic                  dm_done_q;
    logic                  starve_force;
    logic                  grant_dm;
    logic                  grant_if;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    // A fetch that has watched STARVE_LIMIT data grants takes the next slot.
    assign starve_force = bus.if_req && (starve_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!bus.if_req || grant_if)
                starve_d = '0;
            else if (grant_dm)
                starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign grant_dm = bus.dm_req && !starve_force;
    assign grant_if = bus.if_req && !grant_dm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        state_q     <= BUSY_DM;
                    end else if (grant_if) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        state_q     <= BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    if (bus.mem_ready) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_rdata_q <= bus.mem_rdata;
                        if_done_q  <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                BUSY_DM: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q)
                            dm_rdata_q <= bus.mem_rdata;
                        dm_done_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                // Requester still holds req for the finished access here.
                RESP: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps then random traffic
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int LIMIT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];

    int n_cmp = 0;
    int n_bad = 0;

    int wcnt = 0;
    int wtarget = 0;
    int fixed_wait = 0;
    bit rand_wait = 1'b0;
    logic        snap_we = 1'b0;
    logic [5:0]  snap_idx = '0;
    logic [31:0] snap_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wait(input int n);
        fixed_wait = n;
        wtarget = n;
        wcnt = 0;
    endtask

    // Advance to the next falling edge and run the memory responder.
    task automatic cycle();
        @(negedge clk);
        if (bus.mem_ready) begin
            if (snap_we) mem_arr[snap_idx] = snap_wdata;
            bus.mem_ready = 1'b0;
        end else if (bus.mem_req) begin
            if (wcnt >= wtarget) begin
                bus.mem_ready = 1'b1;
                snap_we = bus.mem_we;
                snap_idx = bus.mem_addr[7:2];
                snap_wdata = bus.mem_wdata;
                wcnt = 0;
                wtarget = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
            end else begin
                wcnt++;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
        chk({tag, "_dm_rdata"}, 64'(bus.dm_rdata), 64'd0);
        chk({tag, "_if_done"}, 64'(bus.if_done), 64'd0);
        chk({tag, "_dm_done"}, 64'(bus.dm_done), 64'd0);
        chk({tag, "_stalls"}, 64'({bus.stall_if, bus.stall_mem}), 64'd0);
    endtask

    // Random-phase model state
    bit          pend_if, pend_dm, fl_valid, fl_dm, win_dm, prev_req;
    int          starve, fl_age, ng;
    logic [5:0]  if_idx, dm_idx;
    logic        d_we;
    logic [31:0] d_wdata, exp_if_rd, exp_dm_rd;
    logic [5:0]  exp_order;

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
        mem_arr[16] = 32'h2008_0005;
        mem_arr[8]  = 32'h1234_5678;
        mem_arr[17] = 32'h0badc0de;

        // Reset state
        cycle(); cycle();
        chk_all_zero("reset");
        rst = 1'b0;
        cycle();
        chk_all_zero("post_reset");

        // Single fetch, zero wait
        set_wait(0);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        cycle();
        chk("f1_mem_req", 64'(bus.mem_req), 64'd1);
        chk("f1_mem_addr", 64'(bus.mem_addr), 64'h40);
        chk("f1_mem_we", 64'(bus.mem_we), 64'd0);
        chk("f1_stall_c1", 64'(bus.stall_if), 64'd1);
        cycle();
        chk("f1_if_done", 64'(bus.if_done), 64'd1);
        chk("f1_if_rdata", 64'(bus.if_rdata), 64'h2008_0005);
        chk("f1_stall_c2", 64'(bus.stall_if), 64'd0);
        bus.if_req = 1'b0;
        cycle();
        chk("f1_done_pulse", 64'(bus.if_done), 64'd0);

        // mem_ready without a request is ignored
        snap_we = 1'b0;
        bus.mem_ready = 1'b1;
        cycle();
        chk("spur_done", 64'({bus.if_done, bus.dm_done}), 64'd0);
        chk("spur_req", 64'(bus.mem_req), 64'd0);

        // Store with 3 wait cycles
        set_wait(3);
        bus.dm_req = 1'b1; bus.dm_we = 1'b1;
        bus.dm_addr = 32'h10; bus.dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("st_hold", 64'({bus.mem_req, bus.mem_we, bus.mem_addr,
                                bus.mem_wdata[30:0]}),
                64'({1'b1, 1'b1, 32'h10, 31'h5EAD_BEEF}));
            chk("st_early_done", 64'(bus.dm_done), 64'd0);
        end
        cycle();
        chk("st_done", 64'(bus.dm_done), 64'd1);
        chk("st_rdata_kept", 64'(bus.dm_rdata), 64'd0);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        cycle();
        chk("st_mem_written", 64'(mem_arr[4]), 64'hDEAD_BEEF);

        // Simultaneous load and fetch: data first
        set_wait(0);
        bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        cycle();
        chk("sim_first_addr", 64'(bus.mem_addr), 64'h20);
        chk("sim_stall_if1", 64'(bus.stall_if), 64'd1);
        cycle();
        chk("sim_dm_done", 64'(bus.dm_done), 64'd1);
        chk("sim_dm_rdata", 64'(bus.dm_rdata), 64'h1234_5678);
        chk("sim_stall_if2", 64'(bus.stall_if), 64'd1);
        bus.dm_req = 1'b0;
        cycle();
        chk("sim_idle_req", 64'(bus.mem_req), 64'd0);
        chk("sim_stall_if3", 64'(bus.stall_if), 64'd1);
        cycle();
        chk("sim_fetch_grant", 64'({bus.mem_req, bus.mem_addr}),
            64'({1'b1, 32'h44}));
        cycle();
        chk("sim_if_done", 64'(bus.if_done), 64'd1);
        chk("sim_if_rdata", 64'(bus.if_rdata), 64'h0badc0de);
        bus.if_req = 1'b0;
        cycle();

        // Reset during BUSY_DM
        set_wait(5);
        bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
        cycle();
        chk("rb_busy", 64'(bus.mem_req), 64'd1);
        rst = 1'b1; bus.dm_req = 1'b0;
        cycle();
        chk_all_zero("rb");
        rst = 1'b0; bus.mem_ready = 1'b0; wcnt = 0;
        cycle();
        chk("rb_no_done", 64'({bus.dm_done, bus.mem_req}), 64'd0);

        // Both requesters held continuously: grant order
        set_wait(0);
`ifdef ARB_STARVE_GUARD_EN
        exp_order = 6'b100100;
`else
        exp_order = 6'b000000;
`endif
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        ng = 0; prev_req = 1'b0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            cycle();
            if (bus.mem_req && !prev_req) begin
                chk($sformatf("order_%0d", ng), 64'(bus.mem_addr),
                    exp_order[ng] ? 64'h44 : 64'h20);
                ng++;
            end
            prev_req = bus.mem_req;
        end
        chk("order_count", 64'(ng), 64'd6);
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic against the transaction model
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_arr[i];
        exp_dm_rd = mem_arr[8];
`ifdef ARB_STARVE_GUARD_EN
        exp_if_rd = mem_arr[17];
`else
        exp_if_rd = 32'h0;
`endif
        rand_wait = 1'b1; wtarget = 0; wcnt = 0;
        pend_if = 0; pend_dm = 0; fl_valid = 0; fl_dm = 0;
        starve = 0; fl_age = 0; prev_req = bus.mem_req;
        if_idx = '0; dm_idx = '0; d_we = 1'b0; d_wdata = '0;
        for (int c = 0; c < 1700; c++) begin
            cycle();
            chk("r_stall_if", 64'(bus.stall_if), 64'(pend_if && !bus.if_done));
            chk("r_stall_mem", 64'(bus.stall_mem), 64'(pend_dm && !bus.dm_done));
            if (bus.mem_req && !prev_req) begin
                chk("r_overlap", 64'(fl_valid), 64'd0);
                win_dm = pend_dm;
`ifdef ARB_STARVE_GUARD_EN
                if (pend_if && starve == LIMIT) win_dm = 1'b0;
`endif
                if (win_dm) begin
                    chk("r_dm_grant", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                        64'({d_we, 24'h0, dm_idx, 2'b00, d_wdata}));
                    if (pend_if) starve++;
                end else begin
                    chk("r_if_grant", 64'({pend_if, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                        64'({1'b1, 1'b0, 24'h0, if_idx, 2'b00, 32'h0}));
                end
                fl_valid = 1'b1; fl_dm = win_dm; fl_age = 0;
            end
            prev_req = bus.mem_req;
            if (fl_valid) begin
                fl_age++;
                if (fl_age > 12) begin
                    chk("r_done_timeout", 64'(fl_age), 64'd12);
                    fl_valid = 1'b0;
                end
            end
            if (bus.if_done) begin
                chk("r_if_kind", 64'({fl_valid, fl_dm}), 64'b10);
                exp_if_rd = ref_mem[if_idx];
                chk("r_if_rdata", 64'(bus.if_rdata), 64'(exp_if_rd));
                chk("r_dm_hold", 64'(bus.dm_rdata), 64'(exp_dm_rd));
                fl_valid = 1'b0; pend_if = 1'b0; bus.if_req = 1'b0;
            end
            if (bus.dm_done) begin
                chk("r_dm_kind", 64'({fl_valid, fl_dm}), 64'b11);
                if (d_we) ref_mem[dm_idx] = d_wdata;
                else      exp_dm_rd = ref_mem[dm_idx];
                chk("r_dm_rdata", 64'(bus.dm_rdata), 64'(exp_dm_rd));
                chk("r_if_hold", 64'(bus.if_rdata), 64'(exp_if_rd));
                fl_valid = 1'b0; pend_dm = 1'b0; bus.dm_req = 1'b0;
            end
            if (c < 1500 && !pend_if && $urandom_range(0, 2) == 0) begin
                pend_if = 1'b1; starve = 0;
                if_idx = 6'($urandom_range(0, 63));
                bus.if_req = 1'b1;
                bus.if_addr = {24'h0, if_idx, 2'b00};
            end
            if (c < 1500 && !pend_dm && $urandom_range(0, 2) == 0) begin
                pend_dm = 1'b1;
                dm_idx = 6'($urandom_range(0, 63));
                d_we = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                bus.dm_req = 1'b1; bus.dm_we = d_we;
                bus.dm_addr = {24'h0, dm_idx, 2'b00};
                bus.dm_wdata = d_wdata;
            end
        end
        chk("r_drained", 64'({pend_if, pend_dm, fl_valid}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
